// File: rtl/iob_sram_responder_pkg.sv
// Shared types for the IOb SRAM responder: FSM encoding and latency counter width.
package iob_sram_responder_pkg;
  localparam int LAT_CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;
endpackage

// File: rtl/iob_reg.sv
// Generic register with asynchronous active-low reset and clock enable.
module iob_reg #(
  parameter int                DATA_W  = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)  data_o <= RST_VAL;
    else if (cke_i) data_o <= data_i;
  end
endmodule

// File: rtl/iob_sram_responder.sv
// IOb native bus target in front of a synchronous single-port SRAM.
// Writes complete in the accept cycle; one read is outstanding at a time.
module iob_sram_responder
  import iob_sram_responder_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int MEM_ADDR_W = ADDR_W - 2,
  parameter int READ_LAT   = 1
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  cke_i,
  input  logic                  iob_avalid_i,
  input  logic [ADDR_W-1:0]     iob_addr_i,
  input  logic [DATA_W-1:0]     iob_wdata_i,
  input  logic [DATA_W/8-1:0]   iob_wstrb_i,
  output logic                  iob_ready_o,
  output logic                  iob_rvalid_o,
  output logic [DATA_W-1:0]     iob_rdata_o,
  output logic                  mem_en_o,
  output logic [DATA_W/8-1:0]   mem_we_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0]     mem_d_o,
  input  logic [DATA_W-1:0]     mem_d_i
);
  logic [1:0]           state_raw, state_d;
  state_t               state;
  logic [LAT_CNT_W-1:0] lat_q, lat_d;
  logic [DATA_W-1:0]    rdata_d;
  logic                 rvalid_d;
  logic                 accept;
  logic                 unused_addr_lsb;

  assign state = state_t'(state_raw);

  // Byte lanes come only from wstrb, so the low address bits carry no meaning.
  assign unused_addr_lsb = ^iob_addr_i[1:0];

  assign iob_ready_o = (state == IDLE);
  assign accept      = iob_avalid_i & iob_ready_o & cke_i;
  assign mem_en_o    = accept;
  assign mem_we_o    = accept ? iob_wstrb_i : '0;
  assign mem_addr_o  = iob_addr_i[ADDR_W-1:2];
  assign mem_d_o     = iob_wdata_i;

  always_comb begin
    state_d  = state_raw;
    lat_d    = lat_q;
    rdata_d  = iob_rdata_o;
    rvalid_d = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (iob_wstrb_i == '0)) begin
          state_d = RD_WAIT;
          lat_d   = LAT_CNT_W'(READ_LAT - 1);
        end
      end
      RD_WAIT: begin
        if (lat_q == '0) begin
          rdata_d  = mem_d_i;
          rvalid_d = 1'b1;
          state_d  = RESP;
        end else begin
          lat_d = lat_q - LAT_CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  iob_reg #(.DATA_W(2), .RST_VAL(IDLE)) u_state_reg (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .data_i   (state_d),
    .data_o   (state_raw)
  );

  iob_reg #(.DATA_W(LAT_CNT_W), .RST_VAL('0)) u_lat_reg (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .data_i   (lat_d),
    .data_o   (lat_q)
  );

  iob_reg #(.DATA_W(DATA_W), .RST_VAL('0)) u_rdata_reg (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .data_i   (rdata_d),
    .data_o   (iob_rdata_o)
  );

  // rvalid is registered alongside the RD_WAIT->RESP transition, so it is high exactly in RESP.
  iob_reg #(.DATA_W(1), .RST_VAL(1'b0)) u_rvalid_reg (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .data_i   (rvalid_d),
    .data_o   (iob_rvalid_o)
  );
endmodule

// File: tb/tb_iob_sram_responder.sv
// Scoreboard bench: two responders (READ_LAT 1 and 3) share one SRAM model; sel picks the active one.
module tb_iob_sram_responder;
  localparam int DW = 32, AW = 16, MW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst_n, cke, avalid, sel;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic [DW-1:0] sram_q;

  logic r1, rv1, en1, r3, rv3, en3;
  logic [DW-1:0] rd1, md1, rd3, md3;
  logic [3:0]    we1, we3;
  logic [MW-1:0] ma1, ma3;

  logic          ready, rvalid, m_en;
  logic [DW-1:0] rdata, m_d;
  logic [3:0]    m_we;
  logic [MW-1:0] m_addr;

  iob_sram_responder #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1)) u_dut1 (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
    .iob_avalid_i(avalid & ~sel), .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
    .iob_ready_o(r1), .iob_rvalid_o(rv1), .iob_rdata_o(rd1),
    .mem_en_o(en1), .mem_we_o(we1), .mem_addr_o(ma1), .mem_d_o(md1), .mem_d_i(sram_q)
  );

  iob_sram_responder #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(3)) u_dut3 (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
    .iob_avalid_i(avalid & sel), .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
    .iob_ready_o(r3), .iob_rvalid_o(rv3), .iob_rdata_o(rd3),
    .mem_en_o(en3), .mem_we_o(we3), .mem_addr_o(ma3), .mem_d_o(md3), .mem_d_i(sram_q)
  );

  assign ready  = sel ? r3  : r1;
  assign rvalid = sel ? rv3 : rv1;
  assign rdata  = sel ? rd3 : rd1;
  assign m_en   = sel ? en3 : en1;
  assign m_we   = sel ? we3 : we1;
  assign m_addr = sel ? ma3 : ma1;
  assign m_d    = sel ? md3 : md1;

  // SRAM model: byte-write, read data delayed through a cke-gated pipe.
  logic [DW-1:0] sram [16];
  logic [DW-1:0] pipe [3];
  int sram_reads = 0;
  assign sram_q = sel ? pipe[2] : pipe[0];

  always @(posedge clk) begin
    if (cke) begin
      if (m_en) begin
        for (int b = 0; b < 4; b++)
          if (m_we[b]) sram[m_addr[3:0]][8*b +: 8] <= m_d[8*b +: 8];
        if (m_we == 4'h0) begin
          pipe[0]    <= sram[m_addr[3:0]];
          sram_reads <= sram_reads + 1;
        end
      end
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: memory contents as seen by the bus, and expected responses.
  typedef struct { logic [DW-1:0] data; int at; } exp_t;
  exp_t          q[$];
  logic [DW-1:0] ref_mem [16];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rvalid) begin
        if (q.size() == 0) chk("rvalid_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          chk("rdata", rdata, e.data);
          chk("rvalid_cycle", cyc, e.at);
        end
      end
    end
  end

  // One bus request; for reads, checks the busy window and holds avalid if asked.
  task automatic req(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                     input bit hold, input int stall_len, output int acc);
    int n, lat;
    lat = sel ? 3 : 1;
    @(negedge clk);
    avalid = 1'b1; addr = a; wdata = d; wstrb = s;
    #1;
    n = 0;
    while (!ready && n < 40) begin
      @(negedge clk); #1; n++;
    end
    chk("ready_wait", ready, 1);
    acc = cyc;
    chk("mem_en", m_en, 1);
    chk("mem_we", m_we, s);
    chk("mem_addr", m_addr, a[15:2]);
    if (s != 4'h0) begin
      chk("mem_d", m_d, d);
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
    end else begin
      q.push_back('{data: ref_mem[a[5:2]], at: acc + lat + 1 + stall_len});
      if (stall_len > 0) begin
        @(negedge clk); avalid = 1'b0; cke = 1'b0;
        repeat (stall_len) @(negedge clk);
        cke = 1'b1;
      end else begin
        for (int i = 1; i <= lat + 1; i++) begin
          @(negedge clk); avalid = hold; #1;
          chk("ready_busy", ready, 0);
          chk("mem_en_busy", m_en, 0);
        end
        @(negedge clk); avalid = 1'b0;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk); avalid = 1'b0; wstrb = 4'h0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk); n++;
    end
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic random_ops(input int cnt);
    int acc;
    logic [AW-1:0] a;
    logic [3:0] s;
    for (int i = 0; i < cnt; i++) begin
      a = AW'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
      s = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      req(a, $urandom, s, 1'($urandom_range(0, 1)), 0, acc);
    end
    idle();
  endtask

  initial begin
    int acc, s0;
    int acc4 [4];
    logic [DW-1:0] wv [4];
    arst_n = 1'b0; cke = 1'b1; avalid = 1'b0; sel = 1'b0;
    addr = '0; wdata = '0; wstrb = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;

    #2;
    chk("rst_ready", ready, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    sel = 1'b1; #1;
    chk("rst_ready3", ready, 1);
    chk("rst_rdata3", rdata, 0);
    sel = 1'b0;
    @(negedge clk); arst_n = 1'b1;

    // Known SRAM contents: back-to-back zero writes over the whole window.
    for (int i = 0; i < 16; i++) req(AW'(i * 4), '0, 4'hF, 0, 0, acc);
    idle();

    req(16'h0010, 32'hDEADBEEF, 4'hF, 0, 0, acc);
    idle();
    req(16'h0010, '0, 4'h0, 0, 0, acc);
    req(16'h0010, 32'h0000AAAA, 4'h3, 0, 0, acc);
    idle();
    req(16'h0012, '0, 4'h0, 0, 0, acc);

    for (int i = 0; i < 4; i++) wv[i] = $urandom;
    for (int i = 0; i < 4; i++) req(AW'(i * 4), wv[i], 4'hF, 0, 0, acc4[i]);
    idle();
    for (int i = 1; i < 4; i++) chk("b2b_write_cycle", acc4[i], acc4[0] + i);
    for (int i = 0; i < 4; i++) req(AW'(i * 4), '0, 4'h0, 0, 0, acc);

    random_ops(60);
    drain();

    sel = 1'b1;
    s0 = sram_reads;
    req(16'h0010, '0, 4'h0, 1, 0, acc);
    chk("single_sram_read", sram_reads - s0, 1);
    req(16'h0004, '0, 4'h0, 0, 3, acc);
    random_ops(40);
    drain();

    // Reset in RD_WAIT aborts the read.
    req(16'h0020, 32'h12345678, 4'hF, 0, 0, acc);
    req(16'h0020, '0, 4'h0, 0, 0, acc);
    drain();
    @(negedge clk); avalid = 1'b1; addr = 16'h0020; wstrb = 4'h0; #1;
    chk("rst_rd_accept", ready, 1);
    @(negedge clk); avalid = 1'b0; #1;
    chk("rst_rd_busy", ready, 0);
    arst_n = 1'b0; #1;
    chk("rst_mid_rvalid", rvalid, 0);
    chk("rst_mid_rdata", rdata, 0);
    chk("rst_mid_ready", ready, 1);
    repeat (2) @(negedge clk);
    arst_n = 1'b1; #1;
    chk("rst_rel_ready", ready, 1);
    repeat (6) @(negedge clk);
    chk("rst_rel_rdata", rdata, 0);
    req(16'h0020, '0, 4'h0, 0, 0, acc);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
